// File: rtl/vdp99.sv
// VDP99: Graphics-I video display processor with 640x480@60 VGA timing.
// A CPU data/control port and the video fetch share a 16 KB dual-port VRAM.
module vdp99 (
    input  logic       pxclk,
    input  logic       reset,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic       mode,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    output logic [3:0] color,
    output logic       hsync,
    output logic       vsync
);
    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_LAST = 10'd524;
    localparam logic [9:0] V_FLAG = 10'd432;

    logic [7:0]  vram [0:16383];
    logic [7:0]  regs [0:7];
    logic [13:0] addr;
    logic [7:0]  rbuf;
    logic [7:0]  latch;
    logic        toggle;
    logic        frame_flag;
    logic        ld_pend;
    logic [7:0]  cpu_q;
    logic [7:0]  vid_q;
    logic [13:0] cpu_raddr;
    logic [13:0] vid_addr;
    logic [9:0]  h;
    logic [9:0]  v;

    logic ctrl_wr, data_wr, data_rd, stat_rd, addr_ld;
    logic flag_set;

    always_comb begin
        ctrl_wr   = wr_tick & mode;
        data_wr   = wr_tick & ~mode;
        data_rd   = rd_tick & ~mode & ~wr_tick;
        stat_rd   = rd_tick & mode & ~wr_tick;
        addr_ld   = ctrl_wr & toggle & ~din[7];
        // read-setup points the CPU read port at the new address in the same cycle
        cpu_raddr = addr_ld ? {din[5:0], latch} : addr;
        flag_set  = (h == 10'd0) && (v == V_FLAG);
    end

    always_ff @(posedge pxclk) begin
        if (data_wr) vram[addr] <= din;
        cpu_q <= vram[cpu_raddr];
        vid_q <= vram[vid_addr];
    end

    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            addr       <= 14'h0000;
            rbuf       <= 8'h00;
            latch      <= 8'h00;
            toggle     <= 1'b0;
            ld_pend    <= 1'b0;
            frame_flag <= 1'b0;
        end else begin
            ld_pend <= 1'b0;
            if (ld_pend) rbuf <= cpu_q;
            if (ctrl_wr) begin
                if (!toggle) begin
                    latch  <= din;
                    toggle <= 1'b1;
                end else begin
                    toggle <= 1'b0;
                    if (din[7]) begin
                        regs[din[2:0]] <= latch;
                    end else if (!din[6]) begin
                        addr    <= {din[5:0], latch} + 14'd1;
                        ld_pend <= 1'b1;
                    end else begin
                        addr <= {din[5:0], latch};
                    end
                end
            end else if (data_wr) begin
                addr   <= addr + 14'd1;
                rbuf   <= din;
                toggle <= 1'b0;
            end else if (data_rd) begin
                addr    <= addr + 14'd1;
                ld_pend <= 1'b1;
                toggle  <= 1'b0;
            end else if (stat_rd) begin
                toggle <= 1'b0;
            end
            if (flag_set) frame_flag <= 1'b1;
            else if (stat_rd) frame_flag <= 1'b0;
        end
    end

    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 10'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Tile for column c is fetched during h = 48+16c .. 63+16c and shown from h = 64+16c.
    logic       fetch_win;
    logic [3:0] phase;
    logic [4:0] col_f;
    logic [7:0] pic_y;
    logic [4:0] name_hi;
    logic [7:0] pat_next, col_next, pat_cur, col_cur;

    always_comb begin
        phase     = h[3:0];
        col_f     = h[8:4] - 5'd3;
        pic_y     = v[8:1] - 8'd24;
        fetch_win = (h >= 10'd48) && (h < 10'd560) && (v >= 10'd48) && (v < 10'd432);
        case (phase)
            4'd0:    vid_addr = {regs[2][3:0], pic_y[7:3], col_f};
            4'd1:    vid_addr = {regs[4][2:0], vid_q, pic_y[2:0]};
            default: vid_addr = {regs[3], 1'b0, name_hi};
        endcase
    end

    always_ff @(posedge pxclk or negedge reset) begin
        if (!reset) begin
            name_hi  <= 5'd0;
            pat_next <= 8'h00;
            col_next <= 8'h00;
            pat_cur  <= 8'h00;
            col_cur  <= 8'h00;
        end else if (fetch_win) begin
            case (phase)
                4'd1:  name_hi  <= vid_q[7:3];
                4'd2:  pat_next <= vid_q;
                4'd3:  col_next <= vid_q;
                4'd15: begin
                    pat_cur <= pat_next;
                    col_cur <= col_next;
                end
                default: ;
            endcase
        end
    end

    logic       visible, in_pic, px_bit;
    logic [3:0] nib;

    always_comb begin
        visible = (h < 10'd640) && (v < 10'd480);
        in_pic  = (h >= 10'd64) && (h < 10'd576) && (v >= 10'd48) && (v < 10'd432);
        px_bit  = pat_cur[3'd7 - h[3:1]];
        nib     = px_bit ? col_cur[7:4] : col_cur[3:0];
        if (!visible) color = 4'h0;
        else if (!in_pic || !regs[1][6] || (nib == 4'h0)) color = regs[7][3:0];
        else color = nib;
        hsync = !((h >= 10'd656) && (h <= 10'd751));
        vsync = !((v >= 10'd490) && (v <= 10'd491));
        dout  = mode ? {frame_flag, 7'b0} : rbuf;
        irq   = frame_flag & regs[1][5];
    end
endmodule

// File: tb/tb_vdp99.sv
// Bench for vdp99: CPU port traffic against a VRAM/pointer model, and video
// output against a frame model derived from elapsed pxclk cycles.
`timescale 1ns/1ps
module tb_vdp99;
    logic       pxclk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_tick = 1'b0;
    logic       rd_tick = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;
    logic [3:0] color;
    logic       hsync;
    logic       vsync;

    vdp99 dut (
        .pxclk(pxclk), .reset(reset), .wr_tick(wr_tick), .rd_tick(rd_tick),
        .mode(mode), .din(din), .dout(dout), .irq(irq), .color(color),
        .hsync(hsync), .vsync(vsync)
    );

    always #20 pxclk = ~pxclk;

    int vectors = 0;
    int miscompares = 0;

    // cycles since reset release: h = cyc % 800, v = (cyc / 800) % 525
    int cyc;
    always @(posedge pxclk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    logic [7:0] mem [0:16383];
    logic [7:0] m_reg [0:7];
    int         m_addr;
    logic [7:0] m_buf;

    function automatic logic [3:0] ref_color(input int c);
        int hh, vv, px, py, name, bitpos;
        logic [7:0] pat, col;
        logic [3:0] bd, nb;
        hh = c % 800;
        vv = (c / 800) % 525;
        bd = m_reg[7][3:0];
        if (hh >= 640 || vv >= 480) return 4'h0;
        if (hh < 64 || hh >= 576 || vv < 48 || vv >= 432 || !m_reg[1][6]) return bd;
        px = (hh - 64) / 2;
        py = (vv - 48) / 2;
        name = int'(mem[int'(m_reg[2][3:0]) * 1024 + (py / 8) * 32 + px / 8]);
        pat = mem[int'(m_reg[4][2:0]) * 2048 + name * 8 + py % 8];
        col = mem[(int'(m_reg[3]) * 64 + name / 8) % 16384];
        bitpos = 7 - px % 8;
        nb = pat[bitpos] ? col[7:4] : col[3:0];
        return (nb == 4'h0) ? bd : nb;
    endfunction

    task automatic cpu_write(input logic m, input logic [7:0] d);
        mode = m; din = d; wr_tick = 1'b1;
        @(negedge pxclk); wr_tick = 1'b0;
        @(negedge pxclk); @(negedge pxclk);
    endtask

    task automatic cpu_read(input logic m, output logic [7:0] d);
        mode = m; rd_tick = 1'b1;
        #1 d = dout;
        @(negedge pxclk); rd_tick = 1'b0;
        @(negedge pxclk); @(negedge pxclk);
    endtask

    task automatic set_reg(input int r, input logic [7:0] val);
        cpu_write(1'b1, val);
        cpu_write(1'b1, 8'h80 | 8'(r));
        m_reg[r] = val;
    endtask

    task automatic set_wr_addr(input logic [13:0] a);
        cpu_write(1'b1, a[7:0]);
        cpu_write(1'b1, {2'b01, a[13:8]});
        m_addr = int'(a);
    endtask

    task automatic set_rd_addr(input logic [13:0] a);
        cpu_write(1'b1, a[7:0]);
        cpu_write(1'b1, {2'b00, a[13:8]});
        m_buf = mem[a];
        m_addr = (int'(a) + 1) % 16384;
    endtask

    task automatic vram_wr(input logic [7:0] d);
        cpu_write(1'b0, d);
        mem[m_addr] = d;
        m_buf = d;
        m_addr = (m_addr + 1) % 16384;
    endtask

    task automatic vram_rd(output logic [7:0] got, output logic [7:0] exp);
        cpu_read(1'b0, got);
        exp = m_buf;
        m_buf = mem[m_addr];
        m_addr = (m_addr + 1) % 16384;
    endtask

    task automatic wait_pos(input int hh, input int vv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 420001; i++) begin
            if ((cyc % 800) == hh && ((cyc / 800) % 525) == vv) begin
                ok = 1'b1;
                break;
            end
            @(negedge pxclk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pxclk);
        mode = 1'b0; #1;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout_data: got %h expected 00", dout); end
        mode = 1'b1; #1;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout_status: got %h expected 00", dout); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
        vectors++; if (color !== 4'h0) begin miscompares++; $display("FAIL reset_color: got %h expected 0", color); end
        vectors++; if (hsync !== 1'b1 || vsync !== 1'b1) begin miscompares++; $display("FAIL reset_sync: got %b%b expected 11", hsync, vsync); end
        @(negedge pxclk); reset = 1'b1;
    endtask

    task automatic test_vram_basic();
        logic [7:0] got, exp;
        set_wr_addr(14'h0000);
        vram_wr(8'hAA);
        vram_wr(8'h55);
        set_rd_addr(14'h0000);
        vram_rd(got, exp);
        vectors++; if (got !== 8'hAA || got !== exp) begin miscompares++; $display("FAIL basic_read0: got %h expected AA", got); end
        vram_rd(got, exp);
        vectors++; if (got !== 8'h55 || got !== exp) begin miscompares++; $display("FAIL basic_read1: got %h expected 55", got); end
    endtask

    task automatic test_vram_random();
        logic [7:0] got, exp;
        logic [13:0] a;
        int n;
        for (int r = 0; r < 8; r++) begin
            a = 14'($urandom_range(0, 16383));
            n = $urandom_range(1, 6);
            set_wr_addr(a);
            for (int i = 0; i < n; i++) vram_wr(8'($urandom));
            set_rd_addr(a);
            for (int i = 0; i < n; i++) begin
                vram_rd(got, exp);
                vectors++;
                if (got !== exp) begin miscompares++; $display("FAIL rand_read r%0d i%0d: got %h expected %h", r, i, got, exp); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got, exp;
        logic [7:0] d [0:3];
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        set_wr_addr(14'h3FFE);
        for (int i = 0; i < 4; i++) vram_wr(d[i]);
        set_rd_addr(14'h3FFF);
        for (int i = 1; i < 4; i++) begin
            vram_rd(got, exp);
            vectors++;
            if (got !== exp || got !== d[i]) begin miscompares++; $display("FAIL wrap_read %0d: got %h expected %h", i, got, d[i]); end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] got;
        cpu_write(1'b1, 8'h5A);
        cpu_read(1'b1, got);
        vectors++; if (got !== 8'h00) begin miscompares++; $display("FAIL toggle_status: got %h expected 00", got); end
        cpu_write(1'b1, 8'h12);
        cpu_write(1'b1, 8'h87);
        m_reg[7] = 8'h12;
        for (int i = 0; i < 800; i++) begin
            vectors++;
            if (color !== ref_color(cyc)) begin miscompares++; $display("FAIL toggle_r7 cyc %0d: got %h expected %h", cyc, color, ref_color(cyc)); end
            @(negedge pxclk);
        end
    endtask

    task automatic test_backdrop();
        set_reg(7, 8'h04);
        set_reg(1, 8'h00);
        for (int i = 0; i < 1600; i++) begin
            vectors++;
            if (color !== ref_color(cyc)) begin miscompares++; $display("FAIL backdrop cyc %0d: got %h expected %h", cyc, color, ref_color(cyc)); end
            @(negedge pxclk);
        end
    endtask

    task automatic test_render();
        bit ok;
        int hh, vv;
        logic [3:0] e;
        set_reg(2, 8'h00);
        set_reg(4, 8'h01);
        set_reg(3, 8'h80);
        set_wr_addr(14'h0000);
        for (int i = 0; i < 768; i++) vram_wr((i == 0) ? 8'h00 : 8'($urandom_range(0, 15)));
        set_wr_addr(14'h0800);
        for (int n = 0; n < 16; n++)
            for (int l = 0; l < 8; l++) vram_wr((n == 0) ? 8'hF0 : 8'($urandom));
        set_wr_addr(14'h2000);
        vram_wr(8'hA1);
        vram_wr({4'($urandom_range(1, 15)), 4'h0});
        set_reg(1, 8'h40);
        wait_pos(0, 48, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL render_wait: line 48 not reached"); end
        for (int i = 0; i < 16 * 800; i++) begin
            hh = cyc % 800;
            vv = (cyc / 800) % 525;
            vectors++;
            if (color !== ref_color(cyc)) begin miscompares++; $display("FAIL render h%0d v%0d: got %h expected %h", hh, vv, color, ref_color(cyc)); end
            if (vv == 48 && hh >= 64 && hh < 80) begin
                e = (hh < 72) ? 4'hA : 4'h1;
                vectors++;
                if (color !== e) begin miscompares++; $display("FAIL first_tile h%0d: got %h expected %h", hh, color, e); end
            end
            @(negedge pxclk);
        end
    endtask

    task automatic test_irq();
        bit ok;
        logic [7:0] got;
        set_reg(1, 8'h20);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b expected 0", irq); end
        wait_pos(2, 432, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL irq_wait: line 432 not reached"); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b expected 1", irq); end
        cpu_read(1'b1, got);
        vectors++; if (got !== 8'h80) begin miscompares++; $display("FAIL irq_status: got %h expected 80", got); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
        cpu_read(1'b1, got);
        vectors++; if (got !== 8'h00) begin miscompares++; $display("FAIL flag_clear: got %h expected 00", got); end
    endtask

    task automatic test_sync();
        logic ph = 1'b1, pv = 1'b1, eh, ev;
        int hfall = -1, hper = 0, hwid = 0, vfall = -1, vwid = 0;
        for (int i = 0; i < 49000; i++) begin
            eh = !((cyc % 800) >= 656 && (cyc % 800) <= 751);
            ev = !(((cyc / 800) % 525) >= 490 && ((cyc / 800) % 525) <= 491);
            vectors++;
            if (hsync !== eh || vsync !== ev) begin miscompares++; $display("FAIL sync cyc %0d: got %b%b expected %b%b", cyc, hsync, vsync, eh, ev); end
            if (ph && !hsync) begin if (hfall >= 0) hper = cyc - hfall; hfall = cyc; end
            if (!ph && hsync) hwid = cyc - hfall;
            if (pv && !vsync) vfall = cyc;
            if (!pv && vsync) vwid = cyc - vfall;
            ph = hsync; pv = vsync;
            @(negedge pxclk);
        end
        vectors++; if (hper != 800) begin miscompares++; $display("FAIL hsync_period: got %0d expected 800", hper); end
        vectors++; if (hwid != 96) begin miscompares++; $display("FAIL hsync_width: got %0d expected 96", hwid); end
        vectors++; if (vfall != 490 * 800) begin miscompares++; $display("FAIL vsync_start: got %0d expected %0d", vfall, 490 * 800); end
        vectors++; if (vwid != 1600) begin miscompares++; $display("FAIL vsync_width: got %0d expected 1600", vwid); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] got, exp;
        set_rd_addr(14'h0800);
        set_reg(7, 8'h09);
        mode = 1'b0; rd_tick = 1'b1;
        @(negedge pxclk); rd_tick = 1'b0;
        #5 reset = 1'b0;
        #1;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL abort_dout: got %h expected 00", dout); end
        vectors++; if (color !== 4'h0 || irq !== 1'b0) begin miscompares++; $display("FAIL abort_color_irq: got %h %b expected 0 0", color, irq); end
        vectors++; if (hsync !== 1'b1 || vsync !== 1'b1) begin miscompares++; $display("FAIL abort_sync: got %b%b expected 11", hsync, vsync); end
        mode = 1'b1; #1;
        vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL abort_status: got %h expected 00", dout); end
        @(negedge pxclk); reset = 1'b1;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_addr = 0; m_buf = 8'h00;
        for (int i = 0; i < 100; i++) begin
            vectors++;
            if (color !== ref_color(cyc)) begin miscompares++; $display("FAIL post_reset_color cyc %0d: got %h expected %h", cyc, color, ref_color(cyc)); end
            @(negedge pxclk);
        end
        set_rd_addr(14'h0800);
        vram_rd(got, exp);
        vectors++; if (got !== exp || got !== 8'hF0) begin miscompares++; $display("FAIL vram_retained: got %h expected F0", got); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_addr = 0;
        m_buf = 8'h00;
        test_reset();
        test_vram_basic();
        test_vram_random();
        test_wrap();
        test_toggle();
        test_backdrop();
        test_render();
        test_irq();
        test_sync();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vdp99.md
VDP99 -- requirements
Module: vdp99

Interface
REQ-001 SHALL expose: pxclk  input  1  pixel clock, 25.175 MHz nominal, all logic on rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL expose: wr_tick  input  1  one-pxclk CPU write strobe.
REQ-004 SHALL expose: rd_tick  input  1  one-pxclk CPU read strobe.
REQ-005 SHALL expose: mode  input  1  port select: 0 = VRAM data port, 1 = control/status port.
REQ-006 SHALL expose: din  input  8  CPU write data, sampled when wr_tick=1.
REQ-007 SHALL expose: dout  output  8  CPU read data: mode=0 gives the read-ahead buffer, mode=1 gives status; combinational from mode.
REQ-008 SHALL expose: irq  output  1  active-high interrupt, equal to status F AND R1 bit5 (IE).
REQ-009 SHALL expose: color  output  4  palette index of the current pixel; 0 when blanked.
REQ-010 SHALL expose: hsync, vsync  output  1 each  active-low VGA syncs.

Function
REQ-011 SHALL hold 16 KB internal dual-port VRAM: one port for video fetch, one for CPU; no arbitration stalls.
REQ-012 SHALL hold write-only registers R0..R7 (8 bits each), a 14-bit address pointer, an 8-bit read-ahead buffer, a first-byte latch and a byte-toggle flag.
REQ-013 SHALL, on control write with toggle=0, store din in the latch and set toggle.
REQ-014 SHALL, on control write with toggle=1 and din[7]=1, write latch to R[din[2:0]] and clear toggle.
REQ-015 SHALL, on control write with toggle=1 and din[7]=0, load address = {din[5:0], latch} and clear toggle; if din[6]=0, also load buffer = VRAM[address] and increment address.
REQ-016 SHALL, on data write, store din to VRAM[address], set buffer = din, increment address, clear toggle.
REQ-017 SHALL, on data read, present the old buffer on dout during the rd_tick cycle, then load buffer = VRAM[address], increment address, clear toggle.
REQ-018 SHALL return status = {F, 7'b0} on dout for mode=1.
REQ-019 SHALL, on a status read (rd_tick with mode=1), clear F and the toggle after the tick cycle.
REQ-020 SHALL wrap the address from 16'h3FFF to 0; the 14-bit pointer has no overflow flag.
REQ-021 SHALL complete every CPU access within 2 pxclk cycles; a back-to-back tick 3 or more cycles later SHALL be honoured.
REQ-022 SHALL generate 640x480@60 timing from h counter 0..799 and v counter 0..524.
REQ-023 SHALL drive hsync low for h 656..751 and vsync low for v 490..491.
REQ-024 SHALL treat h<640 and v<480 as visible; color SHALL be 0 outside the visible area.
REQ-025 SHALL map a 256x192 picture, each pixel doubled 2x2, to h 64..575 and v 48..431; the remaining visible area SHALL show backdrop R7[3:0].
REQ-026 SHALL render Graphics I mode only; M1/M2/M3 bits are ignored and sprites are not rendered.
REQ-027 SHALL set the name-table base = R2[3:0]<<10, pattern base = R4[2:0]<<11, colour base = R3<<6.
REQ-028 SHALL fetch per character (col 0..31, row 0..23, line 0..7): name = VRAM[NT+row*32+col], pattern = VRAM[PG+name*8+line], colour = VRAM[CT+name[7:3]].
REQ-029 SHALL output colour[7:4] for pattern bit 1 and colour[3:0] for bit 0, MSB leftmost; a nibble of 0 SHALL show the backdrop.
REQ-030 SHALL prefetch tiles so pixel output is continuous and aligned with h=64.
REQ-031 SHALL show the backdrop over the whole picture when R1 bit6 (BL) = 0.
REQ-032 SHALL set F at the pxclk where h=0, v=432 (end of picture); when a status read coincides, the set SHALL win.

Reset
REQ-033 SHALL, while reset=0, clear R0..R7, address, buffer, latch, toggle, F and counters; dout = 0 (both modes), irq=0, color=0, hsync=1, vsync=1.
REQ-034 SHALL abort any CPU access in progress on reset; VRAM contents are not cleared.

Verification
REQ-035 SHALL pass: control writes 0x00,0x40 then data writes 0xAA,0x55, then control 0x00,0x00, data read, data read -> dout 0xAA then 0x55.
REQ-036 SHALL pass: control writes 0x20,0x81, wait for v=432 -> irq=1; status read -> dout[7]=1, then irq=0 and F=0.
REQ-037 SHALL pass: after reset release, hsync period 800 pxclk with a 96-cycle low pulse; vsync period 420000 cycles with a 1600-cycle low pulse.
REQ-038 SHALL pass: R7=0x04, R1=0x00 -> color=4 throughout the visible area and 0 in blanking.
REQ-039 SHALL pass: NT=0, PG=0x800, CT=0x2000, pattern 0 = 0xF0 on all lines, colour byte 0xA1, BL=1 -> first tile shows 8 pxclks of 0xA, then 8 of 0x1.
REQ-040 SHALL pass: single control write then status read, then control 0x12,0x87 -> R7=0x12 (toggle reset verified).
